// File: rtl/conv_accumulator.sv
// Convolution tap accumulator: sums N_TAPS signed products, adds bias, then
// applies ReLU, fixed-point rescale and unsigned saturation.
module conv_accumulator #(
    parameter int unsigned N_TAPS = 25,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned SHIFT  = 8,
    parameter int unsigned OUT_W  = 9
) (
    input  logic             cnn_clk,
    input  logic             cnn_rst_n,
    input  logic             clear,
    input  logic             prod_valid,
    input  logic [18:0]      prod_data,
    output logic             prod_ready,
    input  logic [15:0]      bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

    localparam int unsigned PROD_W = 19;
    localparam int unsigned BIAS_W = 16;
    localparam int unsigned CNT_W  = $clog2(N_TAPS);
    localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_BIAS = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_tap_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [OUT_W-1:0]   r_dout;
    logic               r_sat;
    logic               r_out_valid;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_tap_cnt_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [OUT_W-1:0]   w_dout_nxt;
    logic               w_sat_nxt;
    logic               w_out_valid_nxt;

    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_bias_ext;
    logic [ACC_W-1:0]   w_relu;
    logic [ACC_W-1:0]   w_scaled;
    logic               w_clip;
    logic [OUT_W-1:0]   w_act;

    assign w_prod_ext = {{(ACC_W - PROD_W){prod_data[PROD_W-1]}}, prod_data};
    assign w_bias_ext = {{(ACC_W - BIAS_W){bias[BIAS_W-1]}}, bias};

    // ReLU leaves a non-negative value, so a logical shift equals the arithmetic one
    assign w_relu   = r_acc[ACC_W-1] ? '0 : r_acc;
    assign w_scaled = w_relu >> SHIFT;
    assign w_clip   = (w_scaled > OUT_MAX);
    assign w_act    = w_clip ? OUT_MAX[OUT_W-1:0] : w_scaled[OUT_W-1:0];

    assign prod_ready = (r_state == ST_ACC);
    assign out_valid  = r_out_valid;
    assign dout       = r_dout;
    assign sat        = r_sat;

    // Next-state and datapath update; clear overrides everything
    always_comb begin
        w_state_nxt     = r_state;
        w_tap_cnt_nxt   = r_tap_cnt;
        w_acc_nxt       = r_acc;
        w_dout_nxt      = r_dout;
        w_sat_nxt       = r_sat;
        w_out_valid_nxt = r_out_valid;

        if (out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        if (clear) begin
            w_state_nxt     = ST_ACC;
            w_tap_cnt_nxt   = '0;
            w_acc_nxt       = '0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (prod_valid) begin
                        w_acc_nxt = (r_tap_cnt == '0) ? w_prod_ext : r_acc + w_prod_ext;
                        if (r_tap_cnt == LAST_TAP) begin
                            w_tap_cnt_nxt = '0;
                            w_state_nxt   = ST_BIAS;
                        end else begin
                            w_tap_cnt_nxt = r_tap_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_BIAS: begin
                    w_acc_nxt   = r_acc + w_bias_ext;
                    w_state_nxt = ST_OUT;
                end
                ST_OUT: begin
                    // Load only when the output register is free or being drained
                    if (!r_out_valid || out_ready) begin
                        w_dout_nxt      = w_act;
                        w_sat_nxt       = w_clip;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = ST_ACC;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACC;
                end
            endcase
        end
    end

    always_ff @(posedge cnn_clk or negedge cnn_rst_n) begin
        if (!cnn_rst_n) begin
            r_state     <= ST_ACC;
            r_tap_cnt   <= '0;
            r_acc       <= '0;
            r_dout      <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tap_cnt   <= w_tap_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_dout      <= w_dout_nxt;
            r_sat       <= w_sat_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_conv_accumulator.sv
// Bench for conv_accumulator: directed scenarios plus a randomized stream
// checked against an arithmetic model of sum + bias -> ReLU -> rescale -> clip.
module tb_conv_accumulator;

    localparam int N_TAPS = 25;
    localparam int SHIFT  = 8;
    localparam int OUT_W  = 9;
    localparam int MAXV   = (1 << OUT_W) - 1;
    localparam int NG     = 1000;

    logic             cnn_clk = 1'b0;
    logic             cnn_rst_n;
    logic             clear;
    logic             prod_valid;
    logic [18:0]      prod_data;
    logic             prod_ready;
    logic [15:0]      bias;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] dout;
    logic             sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 cnn_clk = ~cnn_clk;

    conv_accumulator #(
        .N_TAPS(N_TAPS), .ACC_W(32), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .cnn_clk   (cnn_clk),
        .cnn_rst_n (cnn_rst_n),
        .clear     (clear),
        .prod_valid(prod_valid),
        .prod_data (prod_data),
        .prod_ready(prod_ready),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sat       (sat)
    );

    // Reference: exact integer sum, negative -> 0, divide by 2^SHIFT, clip
    function automatic void ref_out(input longint v, output int d, output bit s);
        longint r;
        r = (v < 0) ? 0 : v;
        r = r / (longint'(1) << SHIFT);
        if (r > MAXV) begin
            d = MAXV;
            s = 1'b1;
        end else begin
            d = int'(r);
            s = 1'b0;
        end
    endfunction

    function automatic int rand_prod();
        logic signed [18:0] t;
        if ($urandom_range(0, 15) == 0) begin
            t = 19'($urandom);
            return int'(t);
        end
        return int'($urandom_range(0, 2400)) - 700;
    endfunction

    function automatic int rand_bias();
        logic signed [15:0] t;
        if ($urandom_range(0, 7) == 0) begin
            t = 16'($urandom);
            return int'(t);
        end
        return int'($urandom_range(0, 8000)) - 4000;
    endfunction

    // Presents n back-to-back taps of one value; returns just after the accepting edge
    task automatic send_group(input int val, input int n, input int b);
        bias = 16'(b);
        for (int i = 0; i < n; i++) begin
            prod_valid = 1'b1;
            prod_data  = 19'(val);
            @(negedge cnn_clk);
        end
        prod_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge cnn_clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        cnn_rst_n = 1'b0; clear = 1'b0; prod_valid = 1'b0; prod_data = '0;
        bias = '0; out_ready = 1'b0;
        #3;
        n_checks++;
        if (prod_ready !== 1'b1 || out_valid !== 1'b0 || dout !== '0 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b dout=%0d sat=%b required 1 0 0 0",
                     prod_ready, out_valid, dout, sat);
        end
        @(negedge cnn_clk);
        @(negedge cnn_clk);
        cnn_rst_n = 1'b1;
        @(negedge cnn_clk);
    endtask

    task automatic test_basic();
        send_group(100, N_TAPS, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_edge1: out_valid=%b required 0", out_valid);
        end
        @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_edge2: out_valid=%b required 0", out_valid);
        end
        @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 9 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_2500: valid=%b dout=%0d sat=%b required 1 9 0", out_valid, dout, sat);
        end
        consume();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_consume: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_negative();
        send_group(100, N_TAPS, -2560);
        repeat (2) @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 0 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_bias: valid=%b dout=%0d sat=%b required 1 0 0", out_valid, dout, sat);
        end
        consume();
        send_group(-1000, N_TAPS, 0);
        repeat (2) @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 0 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_prod: valid=%b dout=%0d sat=%b required 1 0 0", out_valid, dout, sat);
        end
        consume();
    endtask

    task automatic test_saturate();
        send_group(262143, N_TAPS, 32767);
        repeat (2) @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b1 || dout !== MAXV || sat !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate: valid=%b dout=%0d sat=%b required 1 %0d 1",
                     out_valid, dout, sat, MAXV);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_group(100, N_TAPS, 0);
        repeat (2) @(negedge cnn_clk);
        send_group(200, N_TAPS, 0);
        // Offer a stray product while the block sits in BIAS/OUT; it must not be taken
        prod_valid = 1'b1;
        prod_data  = 19'(5000);
        repeat (3) @(negedge cnn_clk);
        n_checks++;
        if (prod_ready !== 1'b0 || out_valid !== 1'b1 || dout !== 9 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL held_first: ready=%b valid=%b dout=%0d sat=%b required 0 1 9 0",
                     prod_ready, out_valid, dout, sat);
        end
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 19 || prod_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL second_load: valid=%b dout=%0d ready=%b required 1 19 1",
                     out_valid, dout, prod_ready);
        end
        @(negedge cnn_clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL second_consume: out_valid=%b required 0", out_valid);
        end
        send_group(100, N_TAPS, 0);
        repeat (2) @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 9) begin
            n_fail++;
            $display("FAIL after_stall: valid=%b dout=%0d required 1 9", out_valid, dout);
        end
        consume();
    endtask

    task automatic test_clear();
        send_group(1000, 10, 0);
        clear      = 1'b1;
        prod_valid = 1'b1;
        prod_data  = 19'(1000);
        @(negedge cnn_clk);
        clear      = 1'b0;
        prod_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_state: valid=%b ready=%b required 0 1", out_valid, prod_ready);
        end
        send_group(100, N_TAPS, 0);
        repeat (2) @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 9 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_group: valid=%b dout=%0d sat=%b required 1 9 0", out_valid, dout, sat);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        send_group(1000, 10, 0);
        #2 cnn_rst_n = 1'b0;
        #1;
        n_checks++;
        if (prod_ready !== 1'b1 || out_valid !== 1'b0 || dout !== '0 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_group: ready=%b valid=%b dout=%0d sat=%b required 1 0 0 0",
                     prod_ready, out_valid, dout, sat);
        end
        @(negedge cnn_clk);
        cnn_rst_n = 1'b1;
        send_group(100, N_TAPS, 0);
        repeat (2) @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b1 || dout !== 9) begin
            n_fail++;
            $display("FAIL rst_group: valid=%b dout=%0d required 1 9", out_valid, dout);
        end
        // Pending output is dropped by a reset while it waits
        #2 cnn_rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || dout !== '0) begin
            n_fail++;
            $display("FAIL rst_pending: valid=%b dout=%0d required 0 0", out_valid, dout);
        end
        @(negedge cnn_clk);
        cnn_rst_n = 1'b1;
        @(negedge cnn_clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_after: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_random();
        int     q_d[$];
        bit     q_s[$];
        int     sent = 0, got = 0, taps = 0, cycles = 0;
        int     cur_bias = 0, cur_val = 0, ed;
        bit     es, need_bias = 1'b1, have_val = 1'b0, hold_chk = 1'b0;
        logic [OUT_W-1:0] hold_d = '0;
        logic   hold_s = 1'b0;
        longint sum = 0;

        prod_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        while (got < NG && cycles < 90000) begin
            if (hold_chk) begin
                n_checks++;
                if (out_valid !== 1'b1 || dout !== hold_d || sat !== hold_s) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%b dout=%0d sat=%b required 1 %0d %b",
                             out_valid, dout, sat, hold_d, hold_s);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (q_d.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: dout=%0d produced with no group outstanding", dout);
                end else begin
                    ed = q_d.pop_front();
                    es = q_s.pop_front();
                    if (dout !== OUT_W'(ed) || sat !== es) begin
                        n_fail++;
                        $display("FAIL rand_result %0d: dout=%0d sat=%b required %0d %b",
                                 got, dout, sat, ed, es);
                    end
                end
                got++;
            end
            hold_chk = (out_valid === 1'b1) && !out_ready;
            hold_d   = dout;
            hold_s   = sat;

            prod_valid = 1'b0;
            if (sent < NG && $urandom_range(0, 3) != 0) begin
                if (!have_val) begin
                    cur_val  = rand_prod();
                    have_val = 1'b1;
                end
                if (need_bias && prod_ready) begin
                    cur_bias  = rand_bias();
                    bias      = 16'(cur_bias);
                    need_bias = 1'b0;
                end
                prod_valid = 1'b1;
                prod_data  = 19'(cur_val);
                if (prod_ready) begin
                    sum     += cur_val;
                    taps++;
                    have_val = 1'b0;
                    if (taps == N_TAPS) begin
                        ref_out(sum + cur_bias, ed, es);
                        q_d.push_back(ed);
                        q_s.push_back(es);
                        sum       = 0;
                        taps      = 0;
                        sent++;
                        need_bias = 1'b1;
                    end
                end
            end
            @(negedge cnn_clk);
            cycles++;
        end
        prod_valid = 1'b0;
        out_ready  = 1'b0;
        n_checks++;
        if (got !== NG) begin
            n_fail++;
            $display("FAIL rand_count: results=%0d required %0d within cycle budget", got, NG);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_saturate();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
